urv_mulh_seq: RTL and testbench
===============================

URV_MULH_SEQ -- requirements
Module: urv_mulh_seq

Interface
REQ-001 Parameters: none; the block has no parameters.
REQ-002 clk_i  in  1  single clock; all logic is on its rising edge.
REQ-003 rst_i  in  1  reset; synchronous and active-high.
REQ-004 start_i  in  1  request; sampled only while busy_o=0.
REQ-005 fun_i  in  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-006 rs1_i, rs2_i  in  32 each  operands; sampled with an accepted start.
REQ-007 busy_o  out  1  operation in progress.
REQ-008 done_o  out  1  one-cycle pulse; rd_o is valid in this cycle.
REQ-009 rd_o  out  32  result; holds its value until the next done_o.
REQ-010 mul_x_o, mul_y_o  out  18 each  operands to the shared registered 18x18 signed multiplier.
REQ-011 mul_ce_o  out  1  multiplier clock enable; multiplier stall = ~mul_ce_o.
REQ-012 mul_q_i  in  36  multiplier product, valid one cycle after mul_ce_o=1.

Function
REQ-013 FSM states: IDLE, ISSUE, ACC, SIGN, DONE.
REQ-014 Start acceptance: start_i=1 in IDLE at cycle T.
- Latches |rs1| and |rs2| as 32-bit magnitudes; signed operands per fun_i (MULH: both; MULHSU: rs1 only).
- Latches neg = sign(rs1) XOR sign(rs2), using only the signed operands.
- Moves to ISSUE with cnt=0.
REQ-015 Magnitude of 0x80000000 = 0x80000000 (unsigned, no overflow).
REQ-016 ISSUE runs cycles T+1..T+4 with cnt=0..3 and mul_ce_o=1.
- Operands are 16-bit chunks zero-extended to 18 bits.
- Order: a0*b0, a0*b1, a1*b0, a1*b1 (a0 = low chunk of |rs1|, a1 = high chunk).
REQ-017 Accumulation happens in cycles T+2..T+5.
- 64-bit acc += mul_q_i[31:0] shifted left by 0, 16, 16, 32 respectively.
- acc is cleared at start acceptance.
- The state after cnt=3 is ACC (cycle T+5).
REQ-018 SIGN (T+6): if neg=1, acc becomes two's complement of acc; zero stays zero.
REQ-019 Result register: rd_o = acc[31:0] for MUL, acc[63:32] otherwise.
REQ-020 DONE (T+7): done_o=1; next state IDLE.
REQ-021 busy_o=1 from T+1 through T+7 inclusive; start-to-done latency is 7 cycles.
REQ-022 start_i while busy_o=1 (including the DONE cycle) is ignored with no side effects.
REQ-023 mul_ce_o=0 outside ISSUE; mul_x_o and mul_y_o are 0 outside ISSUE.
REQ-024 done_o never asserts without a preceding accepted start.

Reset
REQ-025 rst_i=1 forces at the next edge: state IDLE, busy_o=0, done_o=0, rd_o=0, mul_ce_o=0, mul_x_o=0, mul_y_o=0, acc=0, cnt=0.
REQ-026 Reset mid-operation aborts it: no done_o is produced, and a start on the first cycle after reset release is accepted.

Configuration
REQ-027 Macro URV_MUL_FASTPATH_EN.
REQ-028 With URV_MUL_FASTPATH_EN defined, fun=00 (MUL) takes a short path:
- Uses raw operands (no magnitude, neg=0).
- Issues only 3 products at T+1..T+3, skipping a1*b1.
- Goes ACC (T+4) then DONE (T+5), skipping SIGN.
- Latency is 5 cycles; busy_o=1 over T+1..T+5.
REQ-029 Without the macro, MUL uses the full 7-cycle path and returns acc[31:0].
REQ-030 Other fun_i codes are identical with or without the macro.

Verification
REQ-031 MULHU 0xFFFFFFFF x 0xFFFFFFFF, start at T -> done_o at T+7, rd_o=0xFFFFFFFE.
REQ-032 MULH 0x80000000 x 0x80000000 -> rd_o=0x40000000; MULH 0x00000000 x 0x80000000 -> rd_o=0x00000000.
REQ-033 MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> rd_o=0xFFFFFFFF; MULH 0xFFFFFFFD x 0x00000007 -> rd_o=0xFFFFFFFF.
REQ-034 MUL 0x00012345 x 0x00010000 -> rd_o=0x23450000; done_o at T+5 with URV_MUL_FASTPATH_EN, at T+7 without.
REQ-035 Second start_i at T+3 with different operands -> ignored; the first result is unchanged, with a single done_o at T+7.
REQ-036 rst_i=1 at T+3 of a MULHU -> busy_o=0 at T+4, no done_o, rd_o=0; a new start at T+5 completes at T+12 with the correct result.

Source files
------------

// File: rtl/urv_mulh_seq_if.sv
// Request/response bus of the sequential RISC-V multiplier.
// Member names keep the _i/_o suffixes as seen from the multiplier side.
interface urv_mulh_seq_if;
    logic        start_i;
    logic [1:0]  fun_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] rd_o;

    modport master (
        output start_i, fun_i, rs1_i, rs2_i,
        input  busy_o, done_o, rd_o
    );

    modport slave (
        input  start_i, fun_i, rs1_i, rs2_i,
        output busy_o, done_o, rd_o
    );
endinterface

// File: rtl/urv_mulh_seq.sv
// Sequential MUL/MULH/MULHSU/MULHU built on a shared registered 18x18 signed multiplier.
// Optional macro URV_MUL_FASTPATH_EN: MUL issues 3 partial products and skips SIGN.
module urv_mulh_seq (
    input  logic           clk_i,
    input  logic           rst_i,
    urv_mulh_seq_if.slave  bus,
    output logic [17:0]    mul_x_o,
    output logic [17:0]    mul_y_o,
    output logic           mul_ce_o,
    input  logic [35:0]    mul_q_i
);

`ifdef URV_MUL_FASTPATH_EN
    localparam bit FastPath = 1'b1;
`else
    localparam bit FastPath = 1'b0;
`endif

    typedef enum logic [2:0] {StIdle, StIssue, StAcc, StSign, StDone} state_e;

    state_e      r_state, w_state_nxt;
    logic [31:0] r_a, r_b;
    logic        r_neg, r_hi, r_fast;
    logic [1:0]  r_cnt;
    logic [63:0] r_acc;
    logic [31:0] r_rd;
    logic        r_pend;
    logic [5:0]  r_sh;

    logic        w_s1, w_s2, w_fast_sel;
    logic [31:0] w_mag1, w_mag2;
    logic [1:0]  w_last;
    logic [5:0]  w_shift;
    logic [63:0] w_acc_add, w_acc_sgn;
    logic        w_unused;

    // Chunks are zero-extended, so products never exceed 32 bits.
    assign w_unused   = ^mul_q_i[35:32];

    assign w_s1       = bus.rs1_i[31] & ((bus.fun_i == 2'b01) | (bus.fun_i == 2'b10));
    assign w_s2       = bus.rs2_i[31] & (bus.fun_i == 2'b01);
    assign w_mag1     = w_s1 ? (~bus.rs1_i + 32'd1) : bus.rs1_i;
    assign w_mag2     = w_s2 ? (~bus.rs2_i + 32'd1) : bus.rs2_i;
    assign w_fast_sel = FastPath && (bus.fun_i == 2'b00);
    assign w_last     = r_fast ? 2'd2 : 2'd3;
    assign w_shift    = (r_cnt == 2'd0) ? 6'd0 : ((r_cnt == 2'd3) ? 6'd32 : 6'd16);
    assign w_acc_add  = r_acc + ({32'd0, mul_q_i[31:0]} << r_sh);
    assign w_acc_sgn  = r_neg ? (~r_acc + 64'd1) : r_acc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (bus.start_i) w_state_nxt = StIssue;
            StIssue: if (r_cnt == w_last) w_state_nxt = StAcc;
            StAcc:   w_state_nxt = r_fast ? StDone : StSign;
            StSign:  w_state_nxt = StDone;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Partial product order: a0*b0, a0*b1, a1*b0, a1*b1.
    always_comb begin
        mul_ce_o   = (r_state == StIssue);
        mul_x_o    = 18'd0;
        mul_y_o    = 18'd0;
        if (r_state == StIssue) begin
            mul_x_o = {2'b00, r_cnt[1] ? r_a[31:16] : r_a[15:0]};
            mul_y_o = {2'b00, r_cnt[0] ? r_b[31:16] : r_b[15:0]};
        end
        bus.busy_o = (r_state != StIdle);
        bus.done_o = (r_state == StDone);
        bus.rd_o   = r_rd;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_a    <= 32'd0;
            r_b    <= 32'd0;
            r_neg  <= 1'b0;
            r_hi   <= 1'b0;
            r_fast <= 1'b0;
            r_cnt  <= 2'd0;
            r_acc  <= 64'd0;
            r_rd   <= 32'd0;
            r_pend <= 1'b0;
            r_sh   <= 6'd0;
        end else begin
            // Product issued this cycle arrives on mul_q_i next cycle.
            r_pend <= (r_state == StIssue);
            r_sh   <= w_shift;
            if (r_state == StIdle && bus.start_i) begin
                r_a    <= w_mag1;
                r_b    <= w_mag2;
                r_neg  <= w_fast_sel ? 1'b0 : (w_s1 ^ w_s2);
                r_hi   <= (bus.fun_i != 2'b00);
                r_fast <= w_fast_sel;
                r_cnt  <= 2'd0;
                r_acc  <= 64'd0;
            end else begin
                if (r_state == StIssue) begin
                    r_cnt <= (r_cnt == w_last) ? 2'd0 : r_cnt + 2'd1;
                end
                if (r_pend) begin
                    r_acc <= w_acc_add;
                end else if (r_state == StSign) begin
                    r_acc <= w_acc_sgn;
                end
            end
            if (r_state == StSign) begin
                r_rd <= r_hi ? w_acc_sgn[63:32] : w_acc_sgn[31:0];
            end else if (r_state == StAcc && r_fast) begin
                r_rd <= w_acc_add[31:0];
            end
        end
    end

endmodule

// File: tb/tb_urv_mulh_seq.sv
// Directed self-checking bench for urv_mulh_seq with a behavioural registered multiplier.
module tb_urv_mulh_seq;

`ifdef URV_MUL_FASTPATH_EN
    localparam int MulLat = 5;
`else
    localparam int MulLat = 7;
`endif

    logic        clk;
    logic        rst;
    logic [17:0] mul_x, mul_y;
    logic        mul_ce;
    logic [35:0] mul_q;
    int          n_tests;
    int          n_fail;

    urv_mulh_seq_if bus ();

    urv_mulh_seq dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .bus      (bus.slave),
        .mul_x_o  (mul_x),
        .mul_y_o  (mul_y),
        .mul_ce_o (mul_ce),
        .mul_q_i  (mul_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial mul_q = 36'd0;
    always @(posedge clk) begin
        if (mul_ce) mul_q <= $signed(mul_x) * $signed(mul_y);
    end

    // Pulses start for one cycle (called just after a negedge) and watches 20 cycles.
    task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rd, output int lat, output int ndone);
        bus.start_i = 1'b1;
        bus.fun_i   = f;
        bus.rs1_i   = a;
        bus.rs2_i   = b;
        lat   = -1;
        ndone = 0;
        rd    = 32'hxxxxxxxx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            if (bus.done_o) begin
                ndone++;
                if (lat < 0) begin
                    lat = k;
                    rd  = bus.rd_o;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
        n_tests++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done_o); end
        n_tests++; if (bus.rd_o !== 32'd0) begin n_fail++; $display("FAIL reset_rd: got %h want 0", bus.rd_o); end
        n_tests++; if (mul_ce !== 1'b0) begin n_fail++; $display("FAIL reset_ce: got %b want 0", mul_ce); end
        n_tests++; if ({mul_x, mul_y} !== 36'd0) begin n_fail++; $display("FAIL reset_xy: got %h want 0", {mul_x, mul_y}); end
    endtask

    task automatic test_mulhu();
        logic [31:0] rd; int lat, nd;
        run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, rd, lat, nd);
        n_tests++; if (rd !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL mulhu_rd: got %h want FFFFFFFE", rd); end
        n_tests++; if (lat !== 7) begin n_fail++; $display("FAIL mulhu_latency: got %0d want 7", lat); end
        n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL mulhu_ndone: got %0d want 1", nd); end
        n_tests++; if (bus.rd_o !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL mulhu_hold: got %h want FFFFFFFE", bus.rd_o); end
    endtask

    task automatic test_signed();
        logic [31:0] rd; int lat, nd;
        run_op(2'b01, 32'h80000000, 32'h80000000, rd, lat, nd);
        n_tests++; if (rd !== 32'h40000000) begin n_fail++; $display("FAIL mulh_minmin: got %h want 40000000", rd); end
        run_op(2'b01, 32'h00000000, 32'h80000000, rd, lat, nd);
        n_tests++; if (rd !== 32'h00000000) begin n_fail++; $display("FAIL mulh_zero: got %h want 0", rd); end
        run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, rd, lat, nd);
        n_tests++; if (rd !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mulhsu_neg: got %h want FFFFFFFF", rd); end
        run_op(2'b01, 32'hFFFFFFFD, 32'h00000007, rd, lat, nd);
        n_tests++; if (rd !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mulh_neg: got %h want FFFFFFFF", rd); end
        n_tests++; if (lat !== 7) begin n_fail++; $display("FAIL mulh_latency: got %0d want 7", lat); end
    endtask

    task automatic test_mul();
        logic [31:0] rd; int lat, nd;
        run_op(2'b00, 32'h00012345, 32'h00010000, rd, lat, nd);
        n_tests++; if (rd !== 32'h23450000) begin n_fail++; $display("FAIL mul_rd: got %h want 23450000", rd); end
        n_tests++; if (lat !== MulLat) begin n_fail++; $display("FAIL mul_latency: got %0d want %0d", lat, MulLat); end
        run_op(2'b00, 32'hFFFFFFFD, 32'h00000007, rd, lat, nd);
        n_tests++; if (rd !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul_neg: got %h want FFFFFFEB", rd); end
    endtask

    task automatic test_issue_order();
        logic [17:0] ex[4] = '{18'd1, 18'd1, 18'd2, 18'd2};
        logic [17:0] ey[4] = '{18'd3, 18'd4, 18'd3, 18'd4};
        logic [31:0] rd; int lat;
        bus.start_i = 1'b1; bus.fun_i = 2'b11;
        bus.rs1_i = 32'h00020001; bus.rs2_i = 32'h00040003;
        lat = -1; rd = 32'hxxxxxxxx;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            if (k == 1) begin
                n_tests++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL issue_busy: got %b want 1", bus.busy_o); end
            end
            if (k <= 4) begin
                n_tests++;
                if ({mul_ce, mul_x, mul_y} !== {1'b1, ex[k-1], ey[k-1]}) begin
                    n_fail++; $display("FAIL issue_k%0d: got ce=%b x=%h y=%h want ce=1 x=%h y=%h",
                                       k, mul_ce, mul_x, mul_y, ex[k-1], ey[k-1]);
                end
            end
            if (k == 5) begin
                n_tests++; if ({mul_ce, mul_x, mul_y} !== 37'd0) begin n_fail++; $display("FAIL issue_idle: got ce=%b x=%h y=%h want 0", mul_ce, mul_x, mul_y); end
            end
            if (bus.done_o && lat < 0) begin lat = k; rd = bus.rd_o; end
        end
        n_tests++; if (rd !== 32'h00000008) begin n_fail++; $display("FAIL issue_rd: got %h want 00000008", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; int lat, nd;
        bus.start_i = 1'b1; bus.fun_i = 2'b11;
        bus.rs1_i = 32'hFFFFFFFF; bus.rs2_i = 32'hFFFFFFFF;
        lat = -1; nd = 0; rd = 32'hxxxxxxxx;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            bus.start_i = (k == 3) || (k == 7);
            bus.fun_i   = (k == 1) ? 2'b11 : 2'b00;
            bus.rs1_i   = (k == 1) ? 32'hFFFFFFFF : 32'h00000003;
            bus.rs2_i   = (k == 1) ? 32'hFFFFFFFF : 32'h00000005;
            if (bus.done_o) begin nd++; if (lat < 0) begin lat = k; rd = bus.rd_o; end end
            if (k == 8) begin
                n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_after: got %b want 0", bus.busy_o); end
            end
        end
        bus.start_i = 1'b0;
        n_tests++; if (rd !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL b2b_rd: got %h want FFFFFFFE", rd); end
        n_tests++; if (lat !== 7) begin n_fail++; $display("FAIL b2b_latency: got %0d want 7", lat); end
        n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL b2b_ndone: got %0d want 1", nd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; int lat, nd;
        nd = 0;
        bus.start_i = 1'b1; bus.fun_i = 2'b11;
        bus.rs1_i = 32'h12345678; bus.rs2_i = 32'h9ABCDEF0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            rst = (k == 3);
            if (bus.done_o) nd++;
        end
        n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", bus.busy_o); end
        n_tests++; if (bus.rd_o !== 32'd0) begin n_fail++; $display("FAIL rstmid_rd: got %h want 0", bus.rd_o); end
        @(negedge clk);
        if (bus.done_o) nd++;
        n_tests++; if (nd !== 0) begin n_fail++; $display("FAIL rstmid_nodone: got %0d want 0", nd); end
        // 0xFFFFFFFF * 0x00000002 = 0x1_FFFFFFFE
        run_op(2'b11, 32'hFFFFFFFF, 32'h00000002, rd, lat, nd);
        n_tests++; if (rd !== 32'h00000001) begin n_fail++; $display("FAIL rstmid_rd2: got %h want 00000001", rd); end
        n_tests++; if (lat !== 7) begin n_fail++; $display("FAIL rstmid_latency: got %0d want 7", lat); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.fun_i   = 2'b00;
        bus.rs1_i   = 32'd0;
        bus.rs2_i   = 32'd0;
        @(negedge clk);
        test_reset();
        test_mulhu();
        test_signed();
        test_mul();
        test_issue_order();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
